// File: rtl/bitcoin_pkg.sv
// Shared definitions for the hash pipeline (bitcoin_hash and hash_result_scanner).
package bitcoin_pkg;

  localparam int DEFAULT_NUM_NONCES = 16;
  localparam int NONCE_W            = 8;
  localparam int ADDR_W             = 16;
  localparam int WORD_W             = 32;

  typedef logic [NONCE_W-1:0] nonce_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

endpackage

// File: rtl/hash_result_scanner_if.sv
// Read-only result memory port shared by the scanner (master) and the RAM (slave).
interface hash_result_scanner_if;
  import bitcoin_pkg::*;

  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] memory_addr;
  logic [WORD_W-1:0] memory_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output memory_addr,
    input  memory_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  memory_addr,
    output memory_read_data
  );

endinterface

// File: rtl/hash_min_tracker.sv
// Running accumulators for one scan: first match below target, match count,
// and the smallest word seen. Words arrive in ascending nonce order, so a
// strict less-than on the minimum keeps the lower nonce on ties.
module hash_min_tracker
  import bitcoin_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              valid,
  input  nonce_t            nonce,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] target,
  output logic              found,
  output nonce_t            win_nonce,
  output logic [WORD_W-1:0] min_hash,
  output nonce_t            min_nonce,
  output nonce_t            match_count
);

  logic is_match;
  logic is_min;

  assign is_match = word < target;
  assign is_min   = word < min_hash;

  // Clear on scan start, otherwise fold in each valid word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found       <= 1'b0;
      win_nonce   <= '0;
      min_hash    <= '1;
      min_nonce   <= '0;
      match_count <= '0;
    end else if (clear) begin
      found       <= 1'b0;
      win_nonce   <= '0;
      min_hash    <= '1;
      min_nonce   <= '0;
      match_count <= '0;
    end else if (valid) begin
      if (is_match) begin
        match_count <= match_count + 1'b1;
        if (!found) begin
          found     <= 1'b1;
          win_nonce <= nonce;
        end
      end
      if (is_min) begin
        min_hash  <= word;
        min_nonce <= nonce;
      end
    end
  end

endmodule

// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES consecutive hash words from a 1-cycle-latency RAM and
// reports the first/total matches below target and the minimum hash.
//
// state  | meaning
// IDLE   | waiting for start; results from last scan held
// READ   | issuing address base+idx; word for idx-1 arriving
// DRAIN  | last word arriving, no new address
// FINISH | results valid, done pulses
module hash_result_scanner
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = DEFAULT_NUM_NONCES
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            result_addr,
  input  logic [WORD_W-1:0]            target,
  hash_result_scanner_if.master        mem,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output nonce_t                       win_nonce,
  output logic [WORD_W-1:0]            min_hash,
  output nonce_t                       min_nonce,
  output nonce_t                       match_count
);

  localparam nonce_t LAST_IDX = nonce_t'(NUM_NONCES - 1);

  scan_state_t       state;
  nonce_t            idx;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] target_q;

  logic   clear;
  logic   word_valid;
  nonce_t word_nonce;

  assign mem.mem_clk     = clk;
  assign mem.mem_we      = 1'b0;
  assign mem.memory_addr = rd_addr;

  assign clear      = (state == IDLE) && start;
  assign word_valid = ((state == READ) && (idx != '0)) || (state == DRAIN);
  assign word_nonce = (state == DRAIN) ? LAST_IDX : idx - 1'b1;

  // Scan sequencing with registered address, busy and done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      base_addr <= '0;
      rd_addr   <= '0;
      target_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            idx       <= '0;
            base_addr <= result_addr;
            rd_addr   <= result_addr;
            target_q  <= target;
            busy      <= 1'b1;
          end
        end
        READ: begin
          if (idx == LAST_IDX) begin
            state   <= DRAIN;
            rd_addr <= base_addr;
          end else begin
            idx     <= idx + 1'b1;
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          state <= FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  hash_min_tracker u_tracker (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .valid       (word_valid),
    .nonce       (word_nonce),
    .word        (mem.memory_read_data),
    .target      (target_q),
    .found       (found),
    .win_nonce   (win_nonce),
    .min_hash    (min_hash),
    .min_nonce   (min_nonce),
    .match_count (match_count)
  );

endmodule

// File: tb/tb_hash_result_scanner.sv
// Directed bench for hash_result_scanner with a 1-cycle-latency RAM model.
module tb_hash_result_scanner;
  import bitcoin_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] result_addr = '0;
  logic [31:0] target = '0;
  logic        busy, done, found;
  logic [7:0]  win_nonce, min_nonce, match_count;
  logic [31:0] min_hash;

  int total = 0;
  int passed = 0;

  logic [31:0] mem_arr [0:65535];

  hash_result_scanner_if mem_bus ();

  hash_result_scanner #(.NUM_NONCES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .result_addr (result_addr),
    .target      (target),
    .mem         (mem_bus.master),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .win_nonce   (win_nonce),
    .min_hash    (min_hash),
    .min_nonce   (min_nonce),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data follows the address by one cycle.
  always @(posedge clk) mem_bus.memory_read_data <= mem_arr[mem_bus.memory_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chk_res(input string tag, input logic f, input logic [7:0] w,
                         input logic [7:0] cnt, input logic [31:0] mh, input logic [7:0] mn);
    chk({tag, " found"}, {31'd0, found}, {31'd0, f});
    chk({tag, " win_nonce"}, {24'd0, win_nonce}, {24'd0, w});
    chk({tag, " match_count"}, {24'd0, match_count}, {24'd0, cnt});
    chk({tag, " min_hash"}, min_hash, mh);
    chk({tag, " min_nonce"}, {24'd0, min_nonce}, {24'd0, mn});
  endtask

  // Called at a negedge while the DUT is in IDLE; returns at the negedge of
  // the IDLE cycle following FINISH (cycle 19 when start is accepted at edge 0).
  task automatic run_scan(input string tag, input logic [15:0] base,
                          input logic [31:0] tgt, input bit glitch);
    int          cyc;
    int          done_cyc;
    bit          addr_ok, we_ok, busy_ok;
    logic [15:0] exp_a;
    addr_ok = 1; we_ok = 1; busy_ok = 1; done_cyc = 0;
    result_addr = base;
    target = tgt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_cyc == 0 && cyc <= 40) begin
      if (cyc <= 16) begin
        exp_a = base + 16'(cyc - 1);
        if (mem_bus.memory_addr !== exp_a) addr_ok = 0;
      end else if (mem_bus.memory_addr !== base) addr_ok = 0;
      if (mem_bus.mem_we !== 1'b0) we_ok = 0;
      if (cyc <= 17 && busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) done_cyc = cyc;
      if (glitch) begin
        start = (cyc == 5);
        if (cyc == 5) target = 32'hFFFF_FFFF;
      end
      if (done_cyc == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, done_cyc, 18);
    chk({tag, " addr_seq"}, {31'd0, addr_ok}, 1);
    chk({tag, " mem_we_low"}, {31'd0, we_ok}, 1);
    chk({tag, " busy_high"}, {31'd0, busy_ok}, 1);
    @(negedge clk);
    chk({tag, " done_pulse_end"}, {31'd0, done}, 0);
    chk({tag, " idle_addr"}, {16'd0, mem_bus.memory_addr}, {16'd0, base});
  endtask

  initial begin
    int cyc;
    bit no_done;
    for (int a = 0; a < 65536; a++) mem_arr[a] = 32'h0;
    for (int n = 0; n < 16; n++) begin
      mem_arr[16'h0100 + n] = n * 32'h1000_0000 + 32'd1;
      mem_arr[16'h0200 + n] = 32'hFFFF_FFFF;
      mem_arr[16'h0300 + n] = (n == 5 || n == 9) ? 32'h0000_0010 : 32'h7FFF_FFFF;
      mem_arr[16'(32'hFFF8 + n)] = 32'h0000_1000 + (15 - n) * 32'h100;
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst addr", {16'd0, mem_bus.memory_addr}, 0);
    chk("rst mem_we", {31'd0, mem_bus.mem_we}, 0);
    chk_res("rst", 1'b0, 8'd0, 8'd0, 32'hFFFF_FFFF, 8'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_scan("s1", 16'h0100, 32'h3000_0000, 0);
    chk_res("s1", 1'b1, 8'd0, 8'd3, 32'h0000_0001, 8'd0);

    run_scan("s2", 16'h0200, 32'h8000_0000, 0);
    chk_res("s2", 1'b0, 8'd0, 8'd0, 32'hFFFF_FFFF, 8'd0);

    run_scan("tie_eq", 16'h0300, 32'h0000_0010, 0);
    chk_res("tie_eq", 1'b0, 8'd0, 8'd0, 32'h0000_0010, 8'd5);

    run_scan("tie_gl", 16'h0300, 32'h0000_0011, 1);
    chk_res("tie_gl", 1'b1, 8'd5, 8'd2, 32'h0000_0010, 8'd5);

    run_scan("wrap", 16'hFFF8, 32'h0000_1300, 0);
    chk_res("wrap", 1'b1, 8'd13, 8'd3, 32'h0000_1000, 8'd15);
    repeat (5) @(negedge clk);
    chk_res("hold", 1'b1, 8'd13, 8'd3, 32'h0000_1000, 8'd15);

    // Reset in READ cycle 7 of a scan
    result_addr = 16'h0100;
    target = 32'h3000_0000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid found_before", {31'd0, found}, 1);
    reset_n = 1'b0;
    #1;
    chk("mid busy", {31'd0, busy}, 0);
    chk("mid addr", {16'd0, mem_bus.memory_addr}, 0);
    chk_res("mid", 1'b0, 8'd0, 8'd0, 32'hFFFF_FFFF, 8'd0);
    no_done = 1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (cyc = 0; cyc < 25; cyc++) begin
      if (done !== 1'b0) no_done = 0;
      @(negedge clk);
    end
    chk("mid no_done", {31'd0, no_done}, 1);

    run_scan("after_rst", 16'h0100, 32'h3000_0000, 0);
    chk_res("after_rst", 1'b1, 8'd0, 8'd3, 32'h0000_0001, 8'd0);

    // Back-to-back starts in the IDLE cycle right after FINISH
    run_scan("b2b_t1", 16'h0100, 32'h0000_0001, 0);
    chk_res("b2b_t1", 1'b0, 8'd0, 8'd0, 32'h0000_0001, 8'd0);
    run_scan("b2b_t0", 16'h0100, 32'h0000_0000, 0);
    chk_res("b2b_t0", 1'b0, 8'd0, 8'd0, 32'h0000_0001, 8'd0);
    run_scan("b2b_tmax", 16'h0100, 32'hFFFF_FFFF, 0);
    chk_res("b2b_tmax", 1'b1, 8'd0, 8'd16, 32'h0000_0001, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
